// File: rtl/bsc.sv
// Shift-register clock strobe generator.
// Emits a registered one-cycle srClock pulse every DIV clk cycles while
// transEn is high. The pulse fires on the edge where the pre-edge count
// equals PHASE, so the first pulse lands PHASE+1 enabled edges after the
// counter starts from zero. Dropping transEn or asserting rst clears the
// count, so a restart never inherits a partial period.
module bsc #(
    parameter int DIV   = 16,
    parameter int PHASE = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic transEn,
    output logic srClock
);

    localparam int CNT_W = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PHASE = CNT_W'(PHASE);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sr_clock;
    logic             w_cnt_wrap;
    logic             w_phase_hit;

    // Terminal-count and phase compares on the pre-edge count.
    always_comb begin
        w_cnt_wrap  = (r_cnt == CNT_LAST);
        w_phase_hit = (r_cnt == CNT_PHASE);
    end

    // Counter and strobe: reset beats disable, disable beats counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_sr_clock <= 1'b0;
        end else if (!transEn) begin
            r_cnt      <= '0;
            r_sr_clock <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
            r_sr_clock <= w_phase_hit;
        end
    end

    assign srClock = r_sr_clock;

endmodule

// File: tb/tb_bsc.sv
// Directed bench for bsc: one instance with default parameters and one with
// DIV=10, PHASE=4. Each step pushes the expected strobe value into a
// scoreboard queue, clocks once, then pops and compares against the output.
module tb_bsc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, transEn, srClock;
    logic rst_p, en_p, sr_p;

    bsc dut (
        .clk     (clk),
        .rst     (rst),
        .transEn (transEn),
        .srClock (srClock)
    );

    bsc #(.DIV(10), .PHASE(4)) dut_p (
        .clk     (clk),
        .rst     (rst_p),
        .transEn (en_p),
        .srClock (sr_p)
    );

    typedef struct {
        string tag;
        bit    sel;
        logic  exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   pulses      = 0;
    logic prev_sr     = 1'b0;
    logic prev_p      = 1'b0;

    task automatic step(input bit sel, input logic r, input logic e,
                        input logic exp, input string tag);
        exp_t x, y;
        logic obs, prev;
        if (!sel) begin
            rst = r; transEn = e;
        end else begin
            rst_p = r; en_p = e;
        end
        x.tag = tag; x.sel = sel; x.exp = exp;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y    = sb.pop_front();
        obs  = y.sel ? sr_p : srClock;
        prev = y.sel ? prev_p : prev_sr;
        vectors++;
        assert (obs === y.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", y.tag, obs, y.exp);
        end
        vectors++;
        assert ((obs & prev) === 1'b0) else begin
            miscompares++;
            $error("FAIL %s_consecutive: observed %b after %b expected no back-to-back pulse",
                   y.tag, obs, prev);
        end
        if (obs === 1'b1) pulses++;
        if (y.sel) prev_p = obs; else prev_sr = obs;
    endtask

    initial begin
        rst = 1'b0; transEn = 1'b1;
        rst_p = 1'b0; en_p = 1'b0;

        // Reset held two edges with transEn high.
        step(0, 1'b0, 1'b1, 1'b0, "reset_hold");
        step(0, 1'b0, 1'b1, 1'b0, "reset_hold");

        // Steady run: first enabled edge is the cycle after release.
        pulses = 0;
        for (int k = 1; k <= 40; k++)
            step(0, 1'b1, 1'b1, (k == 16 || k == 32), "steady");
        vectors++;
        assert (pulses === 2) else begin
            miscompares++;
            $error("FAIL steady_pulse_count: observed %0d expected 2", pulses);
        end

        // Disable mid-count: 10 on, 3 off, then a full fresh period.
        step(0, 1'b1, 1'b0, 1'b0, "dis_clear");
        for (int k = 1; k <= 10; k++) step(0, 1'b1, 1'b1, 1'b0, "dis_pre");
        for (int k = 1; k <= 3; k++)  step(0, 1'b1, 1'b0, 1'b0, "dis_off");
        pulses = 0;
        for (int k = 1; k <= 20; k++)
            step(0, 1'b1, 1'b1, (k == 16), "dis_reenable");
        vectors++;
        assert (pulses === 1) else begin
            miscompares++;
            $error("FAIL dis_pulse_count: observed %0d expected 1", pulses);
        end

        // Reset mid-count at enabled edge 12.
        step(0, 1'b1, 1'b0, 1'b0, "rst_mid_clear");
        for (int k = 1; k <= 12; k++) step(0, 1'b1, 1'b1, 1'b0, "rst_mid_pre");
        step(0, 1'b0, 1'b1, 1'b0, "rst_mid_reset");
        for (int k = 1; k <= 17; k++)
            step(0, 1'b1, 1'b1, (k == 16), "rst_mid_after");

        // transEn dropped exactly on the pulse-producing edge.
        step(0, 1'b1, 1'b0, 1'b0, "bnd_clear");
        for (int k = 1; k <= 15; k++) step(0, 1'b1, 1'b1, 1'b0, "bnd_pre");
        step(0, 1'b1, 1'b0, 1'b0, "bnd_drop_edge");
        vectors++;
        assert (dut.r_cnt === 4'd0) else begin
            miscompares++;
            $error("FAIL bnd_cnt_zero: observed %0d expected 0", dut.r_cnt);
        end
        for (int k = 1; k <= 17; k++)
            step(0, 1'b1, 1'b1, (k == 16), "bnd_restart");
        step(0, 1'b1, 1'b0, 1'b0, "idle");

        // Parameter sweep DIV=10, PHASE=4.
        step(1, 1'b0, 1'b1, 1'b0, "p_reset");
        pulses = 0;
        for (int k = 1; k <= 35; k++) begin
            step(1, 1'b1, 1'b1, (k == 5 || k == 15 || k == 25 || k == 35), "p_run");
            vectors++;
            assert (dut_p.r_cnt <= 4'd9) else begin
                miscompares++;
                $error("FAIL p_cnt_range: observed %0d expected <= 9", dut_p.r_cnt);
            end
        end
        vectors++;
        assert (pulses === 4) else begin
            miscompares++;
            $error("FAIL p_pulse_count: observed %0d expected 4", pulses);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
